fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage. Reads 14-bit instruction words from instruction RAM as two-word pairs via the shared RAM request/grant handshake. Queues the pairs in a small prefetch buffer and delivers one 28-bit pair on `command_out` per `comm_read` pulse from decode. Supports a PC reload (jump/flush) and a pause input.

---
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: two-word instruction fetch with a prefetch buffer feeding decode.
// Define FETCH_PREFETCH_EN for a two-entry buffer (fetch overlaps decode); default is one entry.
module fetch_unit #(
   parameter int DATA_W   = 14,
   parameter int ADDR_W   = 12,
   parameter int RESET_PC = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pause_FETCH,
   output logic                ram_rd,
   output logic [ADDR_W-1:0]   addr_out,
   input  logic                ram_garant_rd,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                comm_read,
   output logic [2*DATA_W-1:0] command_out,
   output logic [ADDR_W-1:0]   cmd_pc,
   output logic                comm_valid,
   output logic                underflow,
   input  logic                pc_load,
   input  logic [ADDR_W-1:0]   pc_new
);
`ifdef FETCH_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int W = ADDR_W + 2*DATA_W;
   typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI} state_t;
   state_t state, state_next;
   logic [ADDR_W-1:0]  pc, req_addr;
   logic [DATA_W-1:0]  lo;
   logic [DEPTH*W-1:0] q, q_next;
   logic [1:0]         count, count_next, wpos;
   logic               grant, push, pop;
   // a grant only counts while running and not being redirected
   assign grant = ram_garant_rd & ~pause_FETCH & ~pc_load;
   assign push  = (state == REQ_HI) & grant;
   assign pop   = comm_read & (count != 2'd0);
   always_ff @(posedge clk)
      if (reset || pc_load) state <= IDLE;
      else if (!pause_FETCH) state <= state_next;
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = (count < 2'(DEPTH)) ? REQ_LO : IDLE;
         REQ_LO:  state_next = grant ? REQ_HI : REQ_LO;
         REQ_HI:  state_next = grant ? IDLE : REQ_HI;
         default: state_next = IDLE;
      endcase
   end
   always_comb begin
      ram_rd   = (state != IDLE) & ~pause_FETCH;
      req_addr = (state == REQ_HI) ? pc + ADDR_W'(1) : pc;
   end
   assign addr_out = ram_rd ? req_addr : {ADDR_W{1'bz}};
   always_ff @(posedge clk)
      if (reset) begin
         pc <= ADDR_W'(RESET_PC);
         lo <= '0;
      end else if (pc_load) pc <= pc_new;
      else if (state == REQ_LO && grant) lo <= data_in;
      else if (push) pc <= pc + ADDR_W'(2);
   // entry layout {pc, hi, lo}; head lives in the lowest slot
   always_comb begin
      wpos       = count - 2'(pop);
      count_next = count + 2'(push) - 2'(pop);
      q_next     = pop ? q >> W : q;
      if (push) q_next[int'(wpos)*W +: W] = {pc, data_in, lo};
   end
   always_ff @(posedge clk)
      if (reset) begin
         q           <= '0;
         count       <= '0;
         comm_valid  <= 1'b0;
         underflow   <= 1'b0;
         command_out <= '0;
         cmd_pc      <= '0;
      end else if (pc_load) begin
         count      <= '0;
         comm_valid <= 1'b0;
         underflow  <= 1'b0;
         if (comm_read) command_out <= '0;
      end else begin
         q          <= q_next;
         count      <= count_next;
         comm_valid <= count_next != 2'd0;
         underflow  <= comm_read & ~pop;
         if (comm_read) command_out <= pop ? q[2*DATA_W-1:0] : '0;
         if (pop) cmd_pc <= q[W-1:2*DATA_W];
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table and sequence checks for fetch_unit against a simple RAM model.
module tb_fetch_unit;
   logic        clk = 0, reset = 1, pause_FETCH = 0, comm_read = 0, pc_load = 0;
   logic        gnt_on = 1, gnt_force = 0;
   logic [11:0] pc_new = 0;
   logic        ram_rd, ram_garant_rd, comm_valid, underflow;
   logic [11:0] addr_out, cmd_pc;
   logic [13:0] data_in;
   logic [27:0] command_out;
   logic [13:0] mem [4096];
   logic [11:0] log_a [256];
   int lat_lo = 0, lat_hi = 0, waited = 0, nlog = 0, n_chk = 0, n_fail = 0;
`ifdef FETCH_PREFETCH_EN
   localparam int EXP_READS = 4;
`else
   localparam int EXP_READS = 2;
`endif
   typedef struct {
      logic [11:0] pc;
      int          lo_lat;
      int          hi_lat;
      logic [27:0] cmd;
      int          lat;
   } vec_t;
   vec_t tbl [6];

   fetch_unit dut (
      .clk(clk), .reset(reset), .pause_FETCH(pause_FETCH), .ram_rd(ram_rd),
      .addr_out(addr_out), .ram_garant_rd(ram_garant_rd), .data_in(data_in),
      .comm_read(comm_read), .command_out(command_out), .cmd_pc(cmd_pc),
      .comm_valid(comm_valid), .underflow(underflow), .pc_load(pc_load), .pc_new(pc_new)
   );

   always #5 clk = ~clk;
   assign data_in = mem[addr_out];
   assign ram_garant_rd = gnt_force | (ram_rd & gnt_on & (waited >= (addr_out[0] ? lat_hi : lat_lo)));
   always @(posedge clk) begin
      waited <= (reset || !ram_rd || ram_garant_rd) ? 0 : waited + 1;
      if (ram_rd && ram_garant_rd) begin
         log_a[nlog[7:0]] <= addr_out;
         nlog <= nlog + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; comm_read = 0; pc_load = 0; pause_FETCH = 0;
      gnt_on = 1; gnt_force = 0; lat_lo = 0; lat_hi = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int b, k;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[0] = 14'h1A01; mem[1] = 14'h0002; mem[2] = 14'h2003; mem[3] = 14'h0004;
      mem[4] = 14'h0444; mem[5] = 14'h0555; mem[6] = 14'h0666; mem[7] = 14'h0777;
      mem[4095] = 14'h0FFF;
      tbl[0] = '{12'h000, 0, 0, {14'h0002, 14'h1A01}, 4};
      tbl[1] = '{12'h002, 0, 0, {14'h0004, 14'h2003}, 4};
      tbl[2] = '{12'h004, 1, 2, {14'h0555, 14'h0444}, 7};
      tbl[3] = '{12'h005, 0, 0, {14'h0666, 14'h0555}, 4};
      tbl[4] = '{12'hFFF, 0, 0, {14'h1A01, 14'h0FFF}, 4};
      tbl[5] = '{12'h006, 2, 0, {14'h0777, 14'h0666}, 6};

      // reset state, first pair, underflow on empty buffer
      do_reset();
      chk("rst_ram_rd", ram_rd, 0);
      chk("rst_valid", comm_valid, 0);
      chk("rst_uflow", underflow, 0);
      chk("rst_cmd", command_out, 0);
      chk("rst_cmd_pc", cmd_pc, 0);
      nxt(); #1;
      chk("first_rd", ram_rd, 1);
      chk("first_addr_lo", addr_out, 0);
      nxt(); #1;
      chk("first_addr_hi", addr_out, 1);
      nxt(); comm_read = 1; #1;
      chk("first_valid", comm_valid, 1);
      nxt(); #1;
      chk("first_cmd", command_out, {14'h0002, 14'h1A01});
      chk("first_cmd_pc", cmd_pc, 0);
      chk("first_no_uflow", underflow, 0);
      nxt(); comm_read = 0; #1;
      chk("uflow_pulse", underflow, 1);
      chk("uflow_nop", command_out, 0);
      chk("uflow_empty", comm_valid, 0);
      nxt(); #1;
      chk("uflow_single", underflow, 0);

      // buffer full without pops
      do_reset();
      b = nlog;
      repeat (30) nxt();
      #1;
      chk("full_reads", nlog - b, EXP_READS);
      chk("full_rd_low", ram_rd, 0);
      chk("full_valid", comm_valid, 1);

      // hi word grant delayed: address held until granted
      do_reset();
      b = nlog;
      lat_hi = 3;
      nxt(); #1;
      for (int i = 0; i < 4; i++) begin
         nxt(); #1;
         chk("hold_addr", addr_out, 1);
         chk("hold_rd", ram_rd, 1);
         chk("hold_no_push", comm_valid, 0);
      end
      nxt(); #1;
      chk("hold_push", comm_valid, 1);
      chk("hold_reads", nlog - b, 2);
      lat_hi = 0;

      // pc_load to 0xFFF during REQ_HI with a same-cycle grant
      do_reset();
      b = nlog;
      nxt(); #1;
      nxt(); pc_load = 1; pc_new = 12'hFFF; #1;
      chk("load_in_hi", addr_out, 1);
      nxt(); pc_load = 0; #1;
      chk("load_rd_low", ram_rd, 0);
      chk("load_flushed", comm_valid, 0);
      nxt(); #1;
      chk("wrap_lo_addr", addr_out, 12'hFFF);
      nxt(); #1;
      chk("wrap_hi_addr", addr_out, 12'h000);
      nxt(); comm_read = 1; #1;
      chk("wrap_valid", comm_valid, 1);
      nxt(); comm_read = 0; #1;
      chk("wrap_cmd", command_out, {14'h1A01, 14'h0FFF});
      chk("wrap_cmd_pc", cmd_pc, 12'hFFF);
      repeat (6) nxt();
      chk("wrap_log_lo", log_a[8'(b + 2)], 12'hFFF);
      chk("wrap_next_pc", log_a[8'(b + 4)], 12'h001);

      // pause while REQ_LO is pending
      do_reset();
      nxt(); #1;
      nxt(); #1;
      nxt(); gnt_on = 0; comm_read = 1; #1;
      nxt(); comm_read = 0; #1;
      chk("pause_pre_cmd", command_out, {14'h0002, 14'h1A01});
      nxt(); pause_FETCH = 1; #1;
      chk("pause_rd0", ram_rd, 0);
      nxt(); comm_read = 1; #1;
      chk("pause_rd1", ram_rd, 0);
      nxt(); comm_read = 0; gnt_force = 1; #1;
      chk("pause_rd2", ram_rd, 0);
      chk("pause_pop_uflow", underflow, 1);
      chk("pause_pop_nop", command_out, 0);
      nxt(); #1;
      chk("pause_rd3", ram_rd, 0);
      nxt(); gnt_force = 0; #1;
      chk("pause_rd4", ram_rd, 0);
      nxt(); pause_FETCH = 0; gnt_on = 1; #1;
      chk("resume_rd", ram_rd, 1);
      chk("resume_addr", addr_out, 2);
      nxt(); #1;
      chk("resume_hi_addr", addr_out, 3);
      nxt(); #1;
      chk("resume_valid", comm_valid, 1);

      // table: jump, wait for first pair, pop and compare
      foreach (tbl[r]) begin
         nxt();
         lat_lo = tbl[r].lo_lat; lat_hi = tbl[r].hi_lat;
         pc_load = 1; pc_new = tbl[r].pc;
         nxt(); pc_load = 0; #1;
         k = 1;
         while (!comm_valid && k < 20) begin
            nxt(); #1;
            k++;
         end
         chk($sformatf("tbl%0d_latency", r), comm_valid ? k : 99, tbl[r].lat);
         comm_read = 1;
         nxt(); comm_read = 0; #1;
         chk($sformatf("tbl%0d_cmd", r), command_out, tbl[r].cmd);
         chk($sformatf("tbl%0d_cmd_pc", r), cmd_pc, tbl[r].pc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
